// File: rtl/vending_controller_if.sv
// vending_controller_if
// Groups the host-side signals of the vending controller.
//   master : panel/host side - drives sel, coin, cancel, price write port, chgAck;
//            observes credit, LEDs, dispense, coinReject, change handshake, busy.
//   slave  : controller side - the mirror image of master.
// Signals:
//   sel[NUM_SLOTS]       one-hot product request pulse
//   coin[6]              coin pulses: nickel, dime, quarter, fifty, dollar, five
//   cancel               refund request
//   priceWe/Addr/Data    price write port
//   credit[CREDIT_W]     current credit (5-cent units)
//   okLed, soldLed       per-slot affordable-and-stocked / empty indicators
//   dispense             one-cycle vend pulse per slot
//   coinReject           one-cycle pulse for a refused coin
//   chgValid/chgCoin/chgAck  change-return handshake (chgCoin = coin bit index)
//   busy                 controller not idle
interface vending_controller_if #(
    parameter int NUM_SLOTS = 9,
    parameter int CREDIT_W  = 10,
    parameter int PRICE_W   = 8
);
    localparam int ADDR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [NUM_SLOTS-1:0] sel;
    logic [5:0]           coin;
    logic                 cancel;
    logic                 priceWe;
    logic [ADDR_W-1:0]    priceAddr;
    logic [PRICE_W-1:0]   priceData;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_SLOTS-1:0] okLed;
    logic [NUM_SLOTS-1:0] soldLed;
    logic [NUM_SLOTS-1:0] dispense;
    logic                 coinReject;
    logic                 chgValid;
    logic [2:0]           chgCoin;
    logic                 chgAck;
    logic                 busy;

    modport master (
        output sel, coin, cancel, priceWe, priceAddr, priceData, chgAck,
        input  credit, okLed, soldLed, dispense, coinReject, chgValid, chgCoin, busy
    );

    modport slave (
        input  sel, coin, cancel, priceWe, priceAddr, priceData, chgAck,
        output credit, okLed, soldLed, dispense, coinReject, chgValid, chgCoin, busy
    );
endinterface

// File: rtl/vending_controller.sv
// vending_controller
// Coin-operated vending controller: accumulates credit from coin pulses,
// vends a selected slot when credit and stock allow, and returns change one
// coin at a time (largest denomination first) over a valid/ack handshake.
// Ports:
//   clk   - single clock, rising edge
//   rstN  - asynchronous active-low reset
//   bus   - vending_controller_if.slave (see interface file for signal list)
// Build option:
//   VEND_STOCK_EN - when defined, per-slot stock counters (loaded with
//                   INIT_STOCK at reset) limit vending; when undefined every
//                   slot is permanently stocked and soldLed is 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | accepting coins, selections and cancel
// VEND   | one cycle: pulse dispense, deduct price, consume stock
// CHANGE | returning credit coin by coin via chgValid/chgAck
module vending_controller #(
    parameter int NUM_SLOTS  = 9,
    parameter int CREDIT_W   = 10,
    parameter int PRICE_W    = 8,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 5
) (
    input  logic                 clk,
    input  logic                 rstN,
    vending_controller_if.slave  bus
);
    localparam int ADDR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int SUM_W  = CREDIT_W + 1;
    localparam int CMP_W  = (CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W;

    if (STOCK_W < 1 || INIT_STOCK < 0 || INIT_STOCK >= (2 ** STOCK_W)) begin : gBadStockCfg
        $error("INIT_STOCK does not fit in STOCK_W bits");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } stateT;

    function automatic logic [6:0] coinValue(input logic [2:0] code);
        case (code)
            3'd0:    coinValue = 7'd1;
            3'd1:    coinValue = 7'd2;
            3'd2:    coinValue = 7'd5;
            3'd3:    coinValue = 7'd10;
            3'd4:    coinValue = 7'd20;
            3'd5:    coinValue = 7'd100;
            default: coinValue = 7'd0;
        endcase
    endfunction

    // Denominations ascend with code, so the last one that fits is the largest.
    function automatic logic [2:0] bestCoin(input logic [CREDIT_W-1:0] amount);
        bestCoin = 3'd0;
        for (int c = 0; c < 6; c++) begin
            if (CREDIT_W'(coinValue(3'(c))) <= amount) bestCoin = 3'(c);
        end
    endfunction

    stateT                state, stateNext;
    logic [CREDIT_W-1:0]  credit, creditNext;
    logic [PRICE_W-1:0]   price [NUM_SLOTS];
    logic [ADDR_W-1:0]    vendIdx, vendIdxNext;
    logic [PRICE_W-1:0]   vendCost, vendCostNext;
    logic                 coinReject, coinRejectNext;
    logic [NUM_SLOTS-1:0] stocked;
    logic [NUM_SLOTS-1:0] okLed;

    logic                 selOneHot, coinOneHot, coinFits, cancelGo, selGo;
    logic [ADDR_W-1:0]    selIdx;
    logic [PRICE_W-1:0]   selPrice;
    logic [2:0]           coinCode, chgCode;
    logic [SUM_W-1:0]     coinSum;

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0]   stock [NUM_SLOTS];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
        end else if (state == VEND) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (vendIdx == ADDR_W'(i) && stock[i] != '0) stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

    always_comb begin
        stocked = '0;
        for (int i = 0; i < NUM_SLOTS; i++) stocked[i] = (stock[i] != '0);
    end
`else
    assign stocked = '1;
`endif

    always_comb begin
        okLed = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            okLed[i] = (CMP_W'(credit) >= CMP_W'(price[i])) && stocked[i];
        end
    end

    always_comb begin
        selOneHot  = (bus.sel != '0) && ((bus.sel & (bus.sel - NUM_SLOTS'(1))) == '0);
        coinOneHot = (bus.coin != '0) && ((bus.coin & (bus.coin - 6'd1)) == '0);
        selIdx     = '0;
        selPrice   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.sel[i]) begin
                selIdx   = ADDR_W'(i);
                selPrice = price[i];
            end
        end
        coinCode = '0;
        for (int c = 0; c < 6; c++) begin
            if (bus.coin[c]) coinCode = 3'(c);
        end
        // Extra carry bit detects a coin that would overflow the credit register.
        coinSum  = {1'b0, credit} + SUM_W'(coinValue(coinCode));
        coinFits = ~coinSum[CREDIT_W];
        cancelGo = bus.cancel && (credit != '0);
        // okLed already folds in affordability and stock for each slot.
        selGo    = !cancelGo && selOneHot && ((bus.sel & okLed) != '0);
        chgCode  = bestCoin(credit);
    end

    always_comb begin
        stateNext      = state;
        creditNext     = credit;
        vendIdxNext    = vendIdx;
        vendCostNext   = vendCost;
        coinRejectNext = (bus.coin != '0);
        case (state)
            IDLE: begin
                if (cancelGo) begin
                    stateNext = CHANGE;
                end else if (selGo) begin
                    stateNext    = VEND;
                    vendIdxNext  = selIdx;
                    // Latch the price seen at selection so a same-cycle price
                    // write cannot change what this vend costs.
                    vendCostNext = selPrice;
                end else if (coinOneHot && coinFits) begin
                    creditNext     = coinSum[CREDIT_W-1:0];
                    coinRejectNext = 1'b0;
                end
            end
            VEND: begin
                creditNext = credit - CREDIT_W'(vendCost);
                stateNext  = (creditNext != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (bus.chgAck) begin
                    creditNext = credit - CREDIT_W'(coinValue(chgCode));
                    if (creditNext == '0) stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            credit     <= '0;
            vendIdx    <= '0;
            vendCost   <= '0;
            coinReject <= 1'b0;
        end else begin
            state      <= stateNext;
            credit     <= creditNext;
            vendIdx    <= vendIdxNext;
            vendCost   <= vendCostNext;
            coinReject <= coinRejectNext;
        end
    end

    // Out-of-range addresses match no slot and are dropped.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < NUM_SLOTS; i++) price[i] <= PRICE_W'(5 * (i + 1));
        end else if (bus.priceWe) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (bus.priceAddr == ADDR_W'(i)) price[i] <= bus.priceData;
            end
        end
    end

    always_comb begin
        bus.dispense = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (state == VEND && vendIdx == ADDR_W'(i)) bus.dispense[i] = 1'b1;
        end
    end

    assign bus.credit     = credit;
    assign bus.okLed      = okLed;
    assign bus.soldLed    = ~stocked;
    assign bus.coinReject = coinReject;
    assign bus.chgValid   = (state == CHANGE);
    assign bus.chgCoin    = (state == CHANGE) ? chgCode : 3'd0;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller
// Drives directed and random panel activity into vending_controller. A
// behavioural model predicts, per cycle, the visible outputs and the change
// coins to be returned; these go into queues consumed by an independent
// monitor process that samples the DUT on the falling clock edge.
module tb_vending_controller;
    localparam int NS   = 9;
    localparam int CW   = 10;
    localparam int PW   = 8;
    localparam int AW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    vending_controller_if #(.NUM_SLOTS(NS), .CREDIT_W(CW), .PRICE_W(PW)) bus();

    vending_controller #(
        .NUM_SLOTS(NS), .CREDIT_W(CW), .PRICE_W(PW), .STOCK_W(4), .INIT_STOCK(5)
    ) dut (
        .clk(clk),
        .rstN(rstN),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int coinVals [6] = '{1, 2, 5, 10, 20, 100};
    int mCredit;
    int mPrice [NS];
    int mStock [NS];
    int mVendSlot;
    int mVendCost;
    bit mRefund;

    typedef struct {
        int credit;
        int busy;
        int chgValid;
        int chgCoin;
        int ok;
        int sold;
        int disp;
        int rej;
    } recT;

    recT expQ [$];
    int  chgQ [$];

    function automatic int largest(input int amt);
        for (int k = 5; k >= 0; k--) if (coinVals[k] <= amt) return k;
        return 0;
    endfunction

    function automatic bit hasStock(input int i);
`ifdef VEND_STOCK_EN
        return mStock[i] > 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void modelReset();
        mCredit   = 0;
        mVendSlot = -1;
        mVendCost = 0;
        mRefund   = 0;
        for (int i = 0; i < NS; i++) begin
            mPrice[i] = 5 * (i + 1);
            mStock[i] = 5;
        end
    endfunction

    function automatic void modelStep(input logic [NS-1:0] s, input logic [5:0] c, input bit can,
                                      input bit ack, input bit we, input int addr, input int data,
                                      input bit rst);
        recT r;
        bit rej;
        int si;
        int ci;
        bit selOk;
        bit coinOk;
        rej = 0;
        if (rst) begin
            modelReset();
        end else begin
            if (mVendSlot >= 0) begin
                mCredit -= mVendCost;
`ifdef VEND_STOCK_EN
                if (mStock[mVendSlot] > 0) mStock[mVendSlot]--;
`endif
                mRefund   = (mCredit > 0);
                mVendSlot = -1;
                rej = (c != 0);
            end else if (mRefund) begin
                if (ack) begin
                    chgQ.push_back(largest(mCredit));
                    mCredit -= coinVals[largest(mCredit)];
                    if (mCredit == 0) mRefund = 0;
                end
                rej = (c != 0);
            end else begin
                si = -1;
                ci = -1;
                for (int i = 0; i < NS; i++) if (s[i]) si = i;
                for (int k = 0; k < 6; k++) if (c[k]) ci = k;
                selOk  = ($countones(s) == 1) && (mCredit >= mPrice[si]) && hasStock(si);
                coinOk = ($countones(c) == 1) && (mCredit + coinVals[ci] <= MAXC);
                if (can && mCredit > 0) begin
                    mRefund = 1;
                    rej = (c != 0);
                end else if (selOk) begin
                    mVendSlot = si;
                    mVendCost = mPrice[si];
                    rej = (c != 0);
                end else if (coinOk) begin
                    mCredit += coinVals[ci];
                end else begin
                    rej = (c != 0);
                end
            end
            if (we && addr < NS) mPrice[addr] = data;
        end
        r.credit   = mCredit;
        r.busy     = (mVendSlot >= 0 || mRefund) ? 1 : 0;
        r.chgValid = mRefund ? 1 : 0;
        r.chgCoin  = mRefund ? largest(mCredit) : 0;
        r.ok       = 0;
        r.sold     = 0;
        for (int i = 0; i < NS; i++) begin
            if (mCredit >= mPrice[i] && hasStock(i)) r.ok |= (1 << i);
`ifdef VEND_STOCK_EN
            if (mStock[i] == 0) r.sold |= (1 << i);
`endif
        end
        r.disp = (mVendSlot >= 0) ? (1 << mVendSlot) : 0;
        r.rej  = rej ? 1 : 0;
        expQ.push_back(r);
    endfunction

    // ---------------- stimulus ----------------
    task automatic step(input logic [NS-1:0] s, input logic [5:0] c, input bit can, input bit ack,
                        input bit we, input int addr, input int data, input bit rst);
        @(negedge clk);
        #1;
        rstN          = !rst;
        bus.sel       = s;
        bus.coin      = c;
        bus.cancel    = can;
        bus.chgAck    = ack;
        bus.priceWe   = we;
        bus.priceAddr = AW'(addr);
        bus.priceData = PW'(data);
        modelStep(s, c, can, ack, we, addr, data, rst);
    endtask

    task automatic cyc(input logic [NS-1:0] s, input logic [5:0] c, input bit can, input bit ack);
        step(s, c, can, ack, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (mRefund || mVendSlot >= 0); k++) cyc('0, '0, 1'b0, 1'b1);
    endtask

    task automatic buySlot0();
        cyc('0, 6'b000100, 1'b0, 1'b0);
        cyc(NS'(1), '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);
    endtask

    // ---------------- monitor ----------------
    bit         prevValid = 0;
    logic [2:0] prevCoin  = '0;

    initial begin
        recT r;
        forever begin
            @(negedge clk);
            if (prevValid && bus.chgAck && rstN) begin
                if (chgQ.size() == 0) begin
                    check("chg_unexpected", int'(prevCoin), -1);
                end else begin
                    check("chg_coin", int'(prevCoin), chgQ.pop_front());
                end
            end
            prevValid = bus.chgValid;
            prevCoin  = bus.chgCoin;
            if (expQ.size() > 0) begin
                r = expQ.pop_front();
                check("credit",     int'(bus.credit),     r.credit);
                check("busy",       int'(bus.busy),       r.busy);
                check("chgValid",   int'(bus.chgValid),   r.chgValid);
                check("chgCoin",    int'(bus.chgCoin),    r.chgCoin);
                check("okLed",      int'(bus.okLed),      r.ok);
                check("soldLed",    int'(bus.soldLed),    r.sold);
                check("dispense",   int'(bus.dispense),   r.disp);
                check("coinReject", int'(bus.coinReject), r.rej);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [NS-1:0] s;
        logic [5:0]    c;
        bit            can, ack, we, rst;
        int            addr, data, rnd;

        bus.sel = '0; bus.coin = '0; bus.cancel = 0; bus.chgAck = 0;
        bus.priceWe = 0; bus.priceAddr = '0; bus.priceData = '0;
        modelReset();

        @(negedge clk);
        #2;
        check("rst_credit",     int'(bus.credit),     0);
        check("rst_busy",       int'(bus.busy),       0);
        check("rst_chgValid",   int'(bus.chgValid),   0);
        check("rst_chgCoin",    int'(bus.chgCoin),    0);
        check("rst_dispense",   int'(bus.dispense),   0);
        check("rst_coinReject", int'(bus.coinReject), 0);

        // select with no credit
        cyc(NS'(1), '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);

        // quarter then slot 0 (exact price)
        buySlot0();
        cyc('0, '0, 1'b0, 1'b0);

        // dollar then slot 1, change is a fifty
        cyc('0, 6'b010000, 1'b0, 1'b0);
        cyc(NS'(2), '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b0, 1'b1);
        cyc('0, '0, 1'b0, 1'b0);

        // ten fives fill credit to 1000, the eleventh overflows
        for (int k = 0; k < 11; k++) cyc('0, 6'b100000, 1'b0, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);
        cyc('0, 6'b000011, 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        drain();
        cyc('0, '0, 1'b0, 1'b0);

        // seven nickels, cancel, ack held off for three cycles
        for (int k = 0; k < 7; k++) cyc('0, 6'b000001, 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cyc('0, 6'b000001, 1'b0, 1'b0);
        cyc('0, '0, 1'b0, 1'b1);
        cyc('0, '0, 1'b0, 1'b1);
        cyc('0, '0, 1'b0, 1'b0);

        // priority: cancel beats sel beats coin
        cyc('0, 6'b000100, 1'b0, 1'b0);
        cyc(NS'(1), 6'b000001, 1'b1, 1'b0);
        drain();
        cyc('0, 6'b000100, 1'b0, 1'b0);
        cyc(NS'(1), 6'b000001, 1'b0, 1'b0);
        drain();
        cyc(NS'(3), 6'b000001, 1'b1, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        drain();

        // fresh stock, six purchases of slot 0
        step('0, '0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        for (int k = 0; k < 6; k++) buySlot0();
        cyc('0, '0, 1'b1, 1'b0);
        drain();

        // price writes, including out-of-range addresses, then reset mid-refund
        step('0, '0, 1'b0, 1'b0, 1'b1, 2, 3, 1'b0);
        step('0, '0, 1'b0, 1'b0, 1'b1, 12, 1, 1'b0);
        cyc('0, 6'b000010, 1'b0, 1'b0);
        cyc('0, 6'b000001, 1'b0, 1'b0);
        cyc(NS'(4), '0, 1'b0, 1'b0);
        cyc('0, 6'b001000, 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        cyc('0, '0, 1'b0, 1'b0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            s = '0; c = '0; can = 0; ack = 0; we = 0; rst = 0; addr = 0; data = 0;
            rnd = $urandom_range(0, 99);
            if (rnd < 30)      c = 6'(1 << $urandom_range(0, 4));
            else if (rnd < 33) c = 6'b100000;
            else if (rnd < 36) c = 6'($urandom);
            rnd = $urandom_range(0, 99);
            if (rnd < 25)      s = NS'(1 << $urandom_range(0, NS - 1));
            else if (rnd < 28) s = NS'($urandom);
            can = ($urandom_range(0, 99) < 5);
            ack = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 99) < 5) begin
                we   = 1;
                addr = $urandom_range(0, 15);
                data = $urandom_range(0, 40);
            end
            rst = ($urandom_range(0, 399) == 0);
            if (rst) begin
                s = '0; c = '0; can = 0; ack = 0; we = 0;
            end
            step(s, c, can, ack, we, addr, data, rst);
        end
        cyc('0, '0, 1'b1, 1'b0);
        drain();
        cyc('0, '0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        #2;
        check("expQ_drained", expQ.size(), 0);
        check("chgQ_drained", chgQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vending_controller.md
VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 SHALL provide parameter NUM_SLOTS, default 9: number of product slots.
REQ-002 SHALL provide parameter CREDIT_W, default 10: credit register width, unit = 5 cents.
REQ-003 SHALL provide parameter PRICE_W, default 8: price width per slot, unit = 5 cents.
REQ-004 SHALL provide parameter STOCK_W, default 4: stock counter width per slot.
REQ-005 SHALL provide parameter INIT_STOCK, default 5: stock loaded into every slot at reset.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port rstN  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port sel  input  NUM_SLOTS  one-hot product request pulse.
REQ-009 SHALL have port coin  input  6  coin pulses, bit0..5 = nickel, dime, quarter, fifty, dollar, five (1, 2, 5, 10, 20, 100 units).
REQ-010 SHALL have port cancel  input  1  request refund of all credit.
REQ-011 SHALL have ports priceWe input 1, priceAddr input clog2(NUM_SLOTS), priceData input PRICE_W: price write port.
REQ-012 SHALL have port credit  output  CREDIT_W  current credit.
REQ-013 SHALL have ports okLed and soldLed, output NUM_SLOTS each: slot affordable-and-stocked; slot empty.
REQ-014 SHALL have port dispense  output  NUM_SLOTS  one-cycle vend pulse.
REQ-015 SHALL have port coinReject  output  1  one-cycle pulse when a coin is not accepted.
REQ-016 SHALL have ports chgValid output 1, chgCoin output 3 (code = coin bit index), chgAck input 1: change-return handshake.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, VEND and CHANGE.
REQ-019 In IDLE, a single coin bit SHALL add its value to credit next cycle, provided the sum fits in CREDIT_W bits.
REQ-020 A coin that would overflow credit, more than one coin bit in one cycle, or any coin in VEND or CHANGE SHALL leave credit unchanged and pulse coinReject next cycle.
REQ-021 In IDLE, a sel with exactly one bit i set, credit >= price[i] and stock[i] > 0 SHALL enter VEND; otherwise sel SHALL be ignored.
REQ-022 VEND SHALL last one cycle: dispense[i]=1, credit -= price[i], stock[i] -= 1; it SHALL then go to CHANGE if remaining credit > 0, else IDLE.
REQ-023 In IDLE, cancel with credit > 0 SHALL enter CHANGE; cancel with credit 0 SHALL be ignored.
REQ-024 When cancel, sel and coin coincide, priority SHALL be cancel, then sel, then coin; any coin losing arbitration SHALL be rejected.
REQ-025 In CHANGE, chgValid SHALL be 1, and chgCoin SHALL be the largest denomination <= credit, held stable until chgAck is sampled high.
REQ-026 On an accepted chgAck, the denomination SHALL be subtracted from credit; at credit 0, chgValid SHALL drop and the FSM SHALL return to IDLE in the same edge.
REQ-027 okLed[i] SHALL equal (credit >= price[i]) AND (stock[i] > 0); soldLed[i] SHALL equal (stock[i] == 0); both SHALL be combinational from registers.
REQ-028 A price write SHALL be accepted in any state and take effect next cycle; a priceAddr >= NUM_SLOTS SHALL be ignored.

Reset
REQ-029 On rstN low, the block SHALL force: state IDLE, credit 0, every dispense, coinReject and chgValid output 0, chgCoin 0, stock[i] = INIT_STOCK, price[i] = 5*(i+1).
REQ-030 Reset mid-VEND or mid-CHANGE SHALL discard all credit without completing the vend or the refund.

Configuration
REQ-031 With macro VEND_STOCK_EN defined, the block SHALL implement the stock counters as specified.
REQ-032 Without VEND_STOCK_EN, the block SHALL have no stock registers: every slot is always stocked, soldLed = 0, and the stock term in REQ-021/027 is true.

Verification
REQ-033 Reset, sel[0] with credit 0 -> no dispense, okLed[0]=0, busy=0.
REQ-034 quarter (5), then sel[0] (price 5) -> dispense[0] for one cycle, credit 0, back to IDLE, stock[0]=4.
REQ-035 dollar (20), then sel[1] (price 10) -> dispense[1], then chgValid with chgCoin=3; after ack, credit 0 and IDLE.
REQ-036 ten fives (credit 1000), then another five -> coinReject pulse, credit stays 1000.
REQ-037 seven nickels (7), then cancel, chgAck held low 3 cycles -> chgCoin=2 stable, then after ack chgCoin=1; credit 0 after second ack.
REQ-038 six purchases of slot 0 with VEND_STOCK_EN -> sixth not dispensed, soldLed[0]=1; without the macro -> sixth dispensed, soldLed=0.
